// File: rtl/rtc_read_sequencer.sv
// Burst read sequencer for the RTC multiplexed address/data bus.
// Runs N_REGS address/turnaround/read cycles and strobes each captured byte into a register bank.
module rtc_read_sequencer #(
    parameter int unsigned N_REGS    = 6,
    parameter int unsigned T_PHASE   = 4,
    parameter logic [7:0]  ADDR_BASE = 8'h21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        ad_in,
    output logic [7:0]        ad_out,
    output logic              ad_oe,
    output logic              cs_n,
    output logic              ale,
    output logic              rd_n,
    output logic [7:0]        data_out,
    output logic [N_REGS-1:0] ld_en,
    output logic              clr_regs,
    output logic              busy,
    output logic              done
);

    localparam int unsigned        IdxW    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [7:0]         PhLast  = 8'(T_PHASE - 1);
    localparam logic [IdxW-1:0]    IdxLast = IdxW'(N_REGS - 1);
    localparam logic [N_REGS-1:0]  LdOne   = N_REGS'(1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAhold, StTurn, StRead, StLoad, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      phase_q, phase_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            phase_last;

    logic [7:0]        ad_out_d, data_out_d;
    logic [N_REGS-1:0] ld_en_d;
    logic              ad_oe_d, cs_n_d, ale_d, rd_n_d, clr_regs_d, busy_d, done_d;

    always_comb begin
        state_d    = state_q;
        phase_d    = '0;
        idx_d      = idx_q;
        phase_last = (phase_q == PhLast);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAddr;
                    idx_d   = '0;
                end
            end
            StAddr, StAhold, StTurn, StRead: begin
                if (phase_last) begin
                    unique case (state_q)
                        StAddr:  state_d = StAhold;
                        StAhold: state_d = StTurn;
                        StTurn:  state_d = StRead;
                        default: state_d = StLoad;
                    endcase
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            StLoad: begin
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StAddr;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the state being entered so the registers line up with it.
        ad_out_d   = '0;
        ad_oe_d    = 1'b0;
        ale_d      = 1'b0;
        cs_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        ld_en_d    = '0;
        data_out_d = data_out;
        clr_regs_d = (state_q == StIdle) && start;
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);

        if (state_d == StAddr || state_d == StAhold) begin
            ad_out_d = ADDR_BASE + 8'(idx_d);
            ad_oe_d  = 1'b1;
        end
        if (state_d == StAddr) ale_d = 1'b1;
        if (state_d inside {StAddr, StAhold, StTurn, StRead}) cs_n_d = 1'b0;
        if (state_d == StRead) rd_n_d = 1'b0;
        if (state_d == StLoad) ld_en_d = LdOne << idx_d;
        if (state_q == StRead && phase_last) data_out_d = ad_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            idx_q    <= '0;
            ad_out   <= '0;
            ad_oe    <= 1'b0;
            cs_n     <= 1'b1;
            ale      <= 1'b0;
            rd_n     <= 1'b1;
            data_out <= '0;
            ld_en    <= '0;
            clr_regs <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            ad_out   <= ad_out_d;
            ad_oe    <= ad_oe_d;
            cs_n     <= cs_n_d;
            ale      <= ale_d;
            rd_n     <= rd_n_d;
            data_out <= data_out_d;
            ld_en    <= ld_en_d;
            clr_regs <= clr_regs_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Bench for rtc_read_sequencer: default instance plus a small wrapping-address instance.
module tb_rtc_read_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start_a, start_b;
    logic [7:0] ad_in_a, ad_out_a, data_out_a, ad_in_b, ad_out_b, data_out_b;
    logic       ad_oe_a, cs_n_a, ale_a, rd_n_a, clr_a, busy_a, done_a;
    logic       ad_oe_b, cs_n_b, ale_b, rd_n_b, clr_b, busy_b, done_b;
    logic [5:0] ld_en_a;
    logic [2:0] ld_en_b;

    rtc_read_sequencer u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .ad_in(ad_in_a),
        .ad_out(ad_out_a), .ad_oe(ad_oe_a), .cs_n(cs_n_a), .ale(ale_a), .rd_n(rd_n_a),
        .data_out(data_out_a), .ld_en(ld_en_a), .clr_regs(clr_a), .busy(busy_a), .done(done_a)
    );

    rtc_read_sequencer #(.N_REGS(3), .T_PHASE(2), .ADDR_BASE(8'hFE)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .ad_in(ad_in_b),
        .ad_out(ad_out_b), .ad_oe(ad_oe_b), .cs_n(cs_n_b), .ale(ale_b), .rd_n(rd_n_b),
        .data_out(data_out_b), .ld_en(ld_en_b), .clr_regs(clr_b), .busy(busy_b), .done(done_b)
    );

    // RTC model: latch the address on ALE, return address ^ A5 while the strobe is low.
    logic [7:0] lat_a = 8'h00;
    logic [7:0] lat_b = 8'h00;
    always @(negedge clk) if (ale_a) lat_a <= ad_out_a;
    always @(negedge clk) if (ale_b) lat_b <= ad_out_b;
    assign ad_in_a = !rd_n_a ? (lat_a ^ 8'hA5) : 8'h00;
    assign ad_in_b = !rd_n_b ? (lat_b ^ 8'hA5) : 8'h00;

    typedef struct packed {
        logic [7:0] ad_out;
        logic       ad_oe;
        logic       cs_n;
        logic       ale;
        logic       rd_n;
        logic [7:0] data_out;
        logic [5:0] ld_en;
        logic       clr;
        logic       busy;
        logic       done;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t exp;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    snap_t rec [0:127];
    vec_t  vec_a [12];
    vec_t  vec_b [8];

    function automatic snap_t mk(input logic [7:0] ao, input logic oe, input logic cs,
                                 input logic al, input logic rd, input logic [7:0] d,
                                 input logic [5:0] ld, input logic cl, input logic bz,
                                 input logic dn);
        snap_t s;
        s = '{ad_out: ao, ad_oe: oe, cs_n: cs, ale: al, rd_n: rd, data_out: d, ld_en: ld,
              clr: cl, busy: bz, done: dn};
        return s;
    endfunction

    function automatic snap_t idle_snap(input logic [7:0] d);
        return mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, d, 6'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic snap_t grab_a();
        return mk(ad_out_a, ad_oe_a, cs_n_a, ale_a, rd_n_a, data_out_a, ld_en_a,
                  clr_a, busy_a, done_a);
    endfunction

    function automatic snap_t grab_b();
        return mk(ad_out_b, ad_oe_b, cs_n_b, ale_b, rd_n_b, data_out_b, {3'b000, ld_en_b},
                  clr_b, busy_b, done_b);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called in cycle 0; records cycles 0..ncyc, re-pulsing start in cycles rp0/rp1.
    task automatic run(input bit use_b, input int ncyc, input int rp0, input int rp1);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        rec[0] = use_b ? grab_b() : grab_a();
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (use_b) start_b = (c == rp0 || c == rp1);
            else       start_a = (c == rp0 || c == rp1);
            rec[c] = use_b ? grab_b() : grab_a();
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic check_table(input string name, input bit use_b);
        if (use_b) begin
            foreach (vec_b[i])
                check($sformatf("%s_cyc%0d", name, vec_b[i].cyc), 32'(rec[vec_b[i].cyc]),
                      32'(vec_b[i].exp));
        end else begin
            foreach (vec_a[i])
                check($sformatf("%s_cyc%0d", name, vec_a[i].cyc), 32'(rec[vec_a[i].cyc]),
                      32'(vec_a[i].exp));
        end
    endtask

    task automatic protocol(input string name, input int nc, input logic [7:0] base,
                            input int nregs, input int tph);
        int ale_n = 0, bad_addr = 0, overlap = 0, short_gap = 0, multi = 0;
        int clr_n = 0, done_n = 0, done_at = -1, falls = 0;
        logic [7:0] ea;
        for (int c = 0; c <= nc; c++) begin
            if (rec[c].ale) begin
                ale_n++;
                ea = base + 8'((c - 1) / (4 * tph + 1));
                if (rec[c].ad_out !== ea) bad_addr++;
            end
            if (rec[c].ad_oe && !rec[c].rd_n) overlap++;
            if (!$onehot0(rec[c].ld_en)) multi++;
            if (rec[c].clr) clr_n++;
            if (rec[c].done) begin
                done_n++;
                done_at = c;
            end
            if (c > 0 && rec[c-1].rd_n && !rec[c].rd_n) begin
                falls++;
                for (int k = 1; k <= tph; k++)
                    if (c - k < 0 || rec[c-k].ad_oe) short_gap++;
            end
        end
        check({name, "_ale_cycles"}, ale_n, nregs * tph);
        check({name, "_ale_addr"}, bad_addr, 0);
        check({name, "_oe_rd_overlap"}, overlap, 0);
        check({name, "_turnaround"}, short_gap, 0);
        check({name, "_read_count"}, falls, nregs);
        check({name, "_ld_onehot"}, multi, 0);
        check({name, "_clr_count"}, clr_n, 1);
        check({name, "_done_count"}, done_n, 1);
        check({name, "_done_cycle"}, done_at, nregs * (4 * tph + 1) + 1);
    endtask

    initial begin
        int bad;
        start_a = 1'b0;
        start_b = 1'b0;

        vec_a[0]  = '{0,   idle_snap(8'h00)};
        vec_a[1]  = '{1,   mk(8'h21, 1, 0, 1, 1, 8'h00, 6'h00, 1, 1, 0)};
        vec_a[2]  = '{4,   mk(8'h21, 1, 0, 1, 1, 8'h00, 6'h00, 0, 1, 0)};
        vec_a[3]  = '{5,   mk(8'h21, 1, 0, 0, 1, 8'h00, 6'h00, 0, 1, 0)};
        vec_a[4]  = '{9,   mk(8'h00, 0, 0, 0, 1, 8'h00, 6'h00, 0, 1, 0)};
        vec_a[5]  = '{16,  mk(8'h00, 0, 0, 0, 0, 8'h00, 6'h00, 0, 1, 0)};
        vec_a[6]  = '{17,  mk(8'h00, 0, 1, 0, 1, 8'h84, 6'h01, 0, 1, 0)};
        vec_a[7]  = '{18,  mk(8'h22, 1, 0, 1, 1, 8'h84, 6'h00, 0, 1, 0)};
        vec_a[8]  = '{34,  mk(8'h00, 0, 1, 0, 1, 8'h87, 6'h02, 0, 1, 0)};
        vec_a[9]  = '{102, mk(8'h00, 0, 1, 0, 1, 8'h83, 6'h20, 0, 1, 0)};
        vec_a[10] = '{103, mk(8'h00, 0, 1, 0, 1, 8'h83, 6'h00, 0, 1, 1)};
        vec_a[11] = '{104, idle_snap(8'h83)};

        vec_b[0] = '{1,  mk(8'hFE, 1, 0, 1, 1, 8'h00, 6'h00, 1, 1, 0)};
        vec_b[1] = '{9,  mk(8'h00, 0, 1, 0, 1, 8'h5B, 6'h01, 0, 1, 0)};
        vec_b[2] = '{10, mk(8'hFF, 1, 0, 1, 1, 8'h5B, 6'h00, 0, 1, 0)};
        vec_b[3] = '{18, mk(8'h00, 0, 1, 0, 1, 8'h5A, 6'h02, 0, 1, 0)};
        vec_b[4] = '{19, mk(8'h00, 1, 0, 1, 1, 8'h5A, 6'h00, 0, 1, 0)};
        vec_b[5] = '{27, mk(8'h00, 0, 1, 0, 1, 8'hA5, 6'h04, 0, 1, 0)};
        vec_b[6] = '{28, mk(8'h00, 0, 1, 0, 1, 8'hA5, 6'h00, 0, 1, 1)};
        vec_b[7] = '{29, idle_snap(8'hA5)};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (grab_a() !== idle_snap(8'h00)) bad++;
            if (grab_b() !== idle_snap(8'h00)) bad++;
        end
        check("idle_after_reset", bad, 0);

        run(1'b0, 110, -1, -1);
        check_table("burst", 1'b0);
        protocol("burst", 110, 8'h21, 6, 4);
        check("data_held_idle", data_out_a, 8'h83);

        // Re-pulsed start mid-burst must neither restart nor queue a burst.
        run(1'b0, 110, 5, 50);
        protocol("repulse", 110, 8'h21, 6, 4);
        check("repulse_idle_104", rec[104].busy, 1'b0);
        check("repulse_idle_110", rec[110].busy, 1'b0);

        // Reset during READ of index 2.
        run(1'b0, 47, -1, -1);
        check("pre_reset_in_read", {rec[47].busy, rec[47].rd_n}, 2'b10);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(grab_a()), 32'(idle_snap(8'h00)));
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ld_en_a != 6'd0 || busy_a) bad++;
        end
        check("no_ld_during_reset", bad, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run(1'b0, 110, -1, -1);
        check_table("after_reset", 1'b0);
        protocol("after_reset", 110, 8'h21, 6, 4);

        run(1'b1, 35, -1, -1);
        check_table("wrap", 1'b1);
        protocol("wrap", 35, 8'hFE, 3, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
